// File: rtl/exe_stage_if.sv
// ============================================================================
//  exe_stage_if -- ID/EXE operand/control bundle and EXE stage results
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface exe_stage_if;
   logic        freeze;
   logic [3:0]  executeCommand;
   logic        s;
   logic        immediate;
   logic        memRead;
   logic        memWrite;
   logic        branch;
   logic        pushEn;
   logic        popEn;
   logic [31:0] PC;
   logic [31:0] reg1Val;
   logic [31:0] reg2Val;
   logic [11:0] shiftOperand;
   logic [23:0] signedImmediate;
   logic        C;
   logic [31:0] aluResult;
   logic [31:0] branchAddr;
   logic        branchTaken;
   logic [3:0]  srOut;
   logic [31:0] spOut;
   logic        stackErr;

   modport master (
      output freeze, executeCommand, s, immediate, memRead, memWrite, branch,
             pushEn, popEn, PC, reg1Val, reg2Val, shiftOperand, signedImmediate, C,
      input  aluResult, branchAddr, branchTaken, srOut, spOut, stackErr
   );

   modport slave (
      input  freeze, executeCommand, s, immediate, memRead, memWrite, branch,
             pushEn, popEn, PC, reg1Val, reg2Val, shiftOperand, signedImmediate, C,
      output aluResult, branchAddr, branchTaken, srOut, spOut, stackErr
   );
endinterface

`default_nettype wire

// File: rtl/exe_stage.sv
// ============================================================================
//  exe_stage -- execute stage: Val2 generation, ALU, branch target, status
//               register and optional hardware stack (EXE_STAGE_STACK_EN).
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module exe_stage #(
   parameter logic [31:0] STACK_TOP   = 32'h0000_0800,
   parameter int          STACK_DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   exe_stage_if.slave bus
);

   logic [31:0] w_imm32;
   logic [63:0] w_imm_rot;
   logic [63:0] w_reg_rot;
   logic [4:0]  w_shamt;
   logic [31:0] w_shifted;
   logic [31:0] w_val2;

   // Rotations use a doubled word so a right shift exposes the wrapped bits.
   always_comb begin
      w_imm32   = {24'b0, bus.shiftOperand[7:0]};
      w_imm_rot = {w_imm32, w_imm32} >> {bus.shiftOperand[11:8], 1'b0};
      w_shamt   = bus.shiftOperand[11:7];
      w_reg_rot = {bus.reg2Val, bus.reg2Val} >> w_shamt;
      case (bus.shiftOperand[6:5])
         2'b00:   w_shifted = bus.reg2Val << w_shamt;
         2'b01:   w_shifted = bus.reg2Val >> w_shamt;
         2'b10:   w_shifted = $unsigned($signed(bus.reg2Val) >>> w_shamt);
         default: w_shifted = w_reg_rot[31:0];
      endcase
      if (bus.immediate)
         w_val2 = w_imm_rot[31:0];
      else if (bus.memRead || bus.memWrite)
         w_val2 = {20'b0, bus.shiftOperand};
      else
         w_val2 = w_shifted;
   end

   logic [32:0] w_sum;
   logic [31:0] w_res;
   logic        w_arith;
   logic        w_sub;
   logic        w_valid;
   logic        w_b31;
   logic        w_ovf;
   logic [3:0]  w_flags;
   logic [3:0]  r_sr;

   always_comb begin
      w_sum   = 33'd0;
      w_res   = 32'd0;
      w_arith = 1'b0;
      w_sub   = 1'b0;
      w_valid = 1'b1;
      case (bus.executeCommand)
         4'b0001: w_res = w_val2;
         4'b1001: w_res = ~w_val2;
         4'b0010: begin
            w_arith = 1'b1;
            w_sum   = {1'b0, bus.reg1Val} + {1'b0, w_val2};
         end
         4'b0011: begin
            w_arith = 1'b1;
            w_sum   = {1'b0, bus.reg1Val} + {1'b0, w_val2} + {32'd0, bus.C};
         end
         4'b0100: begin
            w_arith = 1'b1;
            w_sub   = 1'b1;
            w_sum   = {1'b0, bus.reg1Val} + {1'b0, ~w_val2} + 33'd1;
         end
         4'b0101: begin
            w_arith = 1'b1;
            w_sub   = 1'b1;
            w_sum   = {1'b0, bus.reg1Val} + {1'b0, ~w_val2} + {32'd0, bus.C};
         end
         4'b0110: w_res = bus.reg1Val & w_val2;
         4'b0111: w_res = bus.reg1Val | w_val2;
         4'b1000: w_res = bus.reg1Val ^ w_val2;
         default: w_valid = 1'b0;
      endcase
      if (w_arith)
         w_res = w_sum[31:0];
      // Overflow: operands share a sign (after inverting for subtract) and the result differs.
      w_b31 = w_sub ? ~w_val2[31] : w_val2[31];
      w_ovf = (bus.reg1Val[31] == w_b31) && (w_res[31] != bus.reg1Val[31]);
      if (!w_valid)
         w_flags = r_sr;
      else
         w_flags = {w_res[31], (w_res == 32'd0),
                    w_arith ? w_sum[32] : r_sr[1],
                    w_arith ? w_ovf     : r_sr[0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_sr <= 4'b0000;
      else if (!bus.freeze && bus.s)
         r_sr <= w_flags;
   end

   assign bus.srOut       = r_sr;
   assign bus.branchAddr  = bus.PC + {{6{bus.signedImmediate[23]}}, bus.signedImmediate, 2'b00};
   assign bus.branchTaken = bus.branch;

`ifdef EXE_STAGE_STACK_EN
   localparam int               c_cnt_w = $clog2(STACK_DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(STACK_DEPTH);

   logic [31:0]        r_sp;
   logic [c_cnt_w-1:0] r_count;
   logic               r_err;
   logic               w_push_ok;
   logic               w_pop_ok;
   logic               w_err;

   always_comb begin
      w_push_ok = bus.pushEn && !bus.popEn && (r_count != c_depth);
      w_pop_ok  = bus.popEn && !bus.pushEn && (r_count != '0);
      w_err     = (bus.pushEn || bus.popEn) && !w_push_ok && !w_pop_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sp    <= STACK_TOP;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (!bus.freeze) begin
         if (w_push_ok) begin
            r_sp    <= r_sp - 32'd4;
            r_count <= r_count + c_cnt_w'(1);
         end else if (w_pop_ok) begin
            r_sp    <= r_sp + 32'd4;
            r_count <= r_count - c_cnt_w'(1);
         end
         if (w_err)
            r_err <= 1'b1;
      end
   end

   // Push wins the address mux even when both enables are raised.
   assign bus.aluResult = bus.pushEn ? (r_sp - 32'd4) : (bus.popEn ? r_sp : w_res);
   assign bus.spOut     = r_sp;
   assign bus.stackErr  = r_err;
`else
   logic w_unused_stack;
   assign w_unused_stack = bus.pushEn | bus.popEn;
   assign bus.aluResult  = w_res;
   assign bus.spOut      = STACK_TOP;
   assign bus.stackErr   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter STACK_TOP, default 32'h0000_0800, SHALL be the stack pointer reset value (empty-stack address, byte address).
REQ-002 Parameter STACK_DEPTH, default 64, SHALL be the maximum number of 32-bit words on the stack.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Ports freeze (in, 1) SHALL, when 1, hold the status register and stack state in the current cycle.
REQ-006 Ports executeCommand (in, 4), s, immediate, memRead, memWrite, branch, pushEn, popEn (in, 1 each) SHALL be the control fields issued by the ID/EXE register.
REQ-007 Ports PC, reg1Val, reg2Val (in, 32 each), shiftOperand (in, 12), signedImmediate (in, 24), C (in, 1) SHALL be the operand fields issued by the ID/EXE register.
REQ-008 Port aluResult, output, 32, SHALL carry the ALU result, or the stack address during push/pop.
REQ-009 Ports branchAddr (out, 32) and branchTaken (out, 1) SHALL carry the branch target and branch request.
REQ-010 Port srOut, output, 4, SHALL carry the registered status flags {N,Z,C,V} back to the decode stage.
REQ-011 Ports spOut (out, 32) and stackErr (out, 1) SHALL carry the stack pointer and the sticky stack error flag.

Function
REQ-012 Val2 SHALL be: if immediate, {24'b0,shiftOperand[7:0]} rotated right by 2*shiftOperand[11:8]; else if memRead|memWrite, {20'b0,shiftOperand}; else reg2Val shifted by shiftOperand[11:7] with type shiftOperand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-013 ALU SHALL implement executeCommand: 0001 MOV Val2; 1001 MVN ~Val2; 0010 ADD; 0011 ADC (+C); 0100 SUB; 0101 SBC (-~C); 0110 AND; 0111 ORR; 1000 EOR; any other code yields 0 and flags unchanged.
REQ-014 ALU N SHALL be result[31], Z SHALL be result==0; C and V SHALL be computed for ADD/ADC/SUB/SBC only (C = carry-out for add, no-borrow for subtract), and passed through from srOut for logic ops.
REQ-015 aluResult, branchAddr and branchTaken SHALL be combinational (zero-cycle latency) from the inputs.
REQ-016 branchAddr SHALL equal PC + (sign-extended signedImmediate << 2), modulo 2^32; branchTaken SHALL equal branch.
REQ-017 Status register SHALL load the ALU {N,Z,C,V} at the clock edge when s=1 and freeze=0, else hold.
REQ-018 A push (pushEn=1, popEn=0) with count<STACK_DEPTH SHALL drive aluResult=SP-4 and, at the edge, set SP=SP-4, count=count+1.
REQ-019 A pop (popEn=1, pushEn=0) with count>0 SHALL drive aluResult=SP and, at the edge, set SP=SP+4, count=count-1.
REQ-020 Push when count==STACK_DEPTH (full), pop when count==0 (empty), or pushEn&popEn SHALL leave SP/count unchanged and set stackErr=1 at the edge; aluResult still follows REQ-018/019 (push priority).
REQ-021 stackErr SHALL remain 1 until reset.
REQ-022 freeze=1 SHALL suppress SR, SP, count and stackErr updates in that cycle; combinational outputs SHALL remain valid.

Reset
REQ-023 rst=1 SHALL immediately set srOut=4'b0000, spOut=STACK_TOP, count=0, stackErr=0, regardless of clk.
REQ-024 Reset mid-push/pop SHALL discard that operation; the first edge after rst falls SHALL behave as from the reset state.

Configuration
REQ-025 Macro EXE_STAGE_STACK_EN defined SHALL include the stack pointer, count and stackErr logic per REQ-018..022.
REQ-026 Without EXE_STAGE_STACK_EN, pushEn/popEn SHALL be ignored, spOut SHALL be constant STACK_TOP, stackErr constant 0, and aluResult SHALL always be the ALU result.

Verification
REQ-027 ADD reg1Val=32'hFFFF_FFFF, Val2 imm 1, s=1 -> aluResult=0, srOut becomes 4'b0110 after edge.
REQ-028 SUB reg1Val=5, reg2Val=7 LSL 0, s=1 -> aluResult=32'hFFFF_FFFE, srOut=4'b1000 after edge; with s=0 srOut unchanged.
REQ-029 immediate=1, shiftOperand=12'h1FF -> Val2=32'hC000_003F; MOV result equals it.
REQ-030 PC=32'h100, signedImmediate=24'hFFFFFE, branch=1 -> branchAddr=32'h0F8, branchTaken=1.
REQ-031 (STACK_EN) 64 pushes then 65th push -> spOut=32'h0700, stackErr=1; pop from reset -> spOut=32'h0800, stackErr=1.
REQ-032 (STACK_EN) push with freeze=1, then rst pulse between edges -> SP/SR unchanged while frozen; rst clears to STACK_TOP/0 without a clock edge.
